// File: rtl/lcd_i2c_pkg.sv
// rtl/lcd_i2c_pkg.sv - shared constants, FSM states and bus-drive helper for the LCD I2C sequencer
package lcd_i2c_pkg;

    localparam logic [1:0] ADDR_CMD     = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CLKDIV  = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int START_BIT = 8;
    localparam int STOP_BIT  = 9;
    localparam int ST_BUSY   = 0;
    localparam int ST_NACK   = 1;
    localparam int ST_ERR    = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START1,
        S_START2,
        S_BIT_LO,
        S_BIT_HI,
        S_ACK_LO,
        S_ACK_HI,
        S_HOLD,
        S_STOP1,
        S_STOP2,
        S_STOP3
    } state_t;

    // {scl_oe, sda_oe} a state drives for its whole duration; IDLE keeps the previous pair
    function automatic logic [1:0] bus_drive(state_t st, logic data_bit);
        case (st)
            S_START1: bus_drive = 2'b01;
            S_START2: bus_drive = 2'b11;
            S_BIT_LO: bus_drive = {1'b1, ~data_bit};
            S_BIT_HI: bus_drive = {1'b0, ~data_bit};
            S_ACK_LO: bus_drive = 2'b10;
            S_ACK_HI: bus_drive = 2'b00;
            S_HOLD:   bus_drive = 2'b10;
            S_STOP1:  bus_drive = 2'b11;
            S_STOP2:  bus_drive = 2'b01;
            default:  bus_drive = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lcd_i2c_seq_if.sv
// rtl/lcd_i2c_seq_if.sv - register bus between the CPU interconnect and the LCD I2C sequencer
interface lcd_i2c_seq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/lcd_i2c_clkdiv.sv
// rtl/lcd_i2c_clkdiv.sv - half-period divider: counts 0..div while enabled, tick on the last count
module lcd_i2c_clkdiv #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en & (cnt == div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == div) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_i2c_seq.sv
// rtl/lcd_i2c_seq.sv - register-driven byte sequencer for the LCD panel I2C bus (START, 8 bits, ACK, STOP)
module lcd_i2c_seq
    import lcd_i2c_pkg::*;
#(
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = 16'd249
) (
    input  logic          clk,
    input  logic          reset_n,
    lcd_i2c_seq_if.slave  bus,
    output logic          lcd_i2c_en,
    output logic          scl_oe,
    output logic          sda_oe,
    input  logic          sda_in
);

    state_t           state, state_nx;
    logic [7:0]       shift, shift_nx;
    logic [2:0]       bit_cnt, bit_cnt_nx;
    logic             stop_f, stop_f_nx;
    logic             busy, busy_nx;
    logic             nack, err;
    logic             nack_set;
    logic             done;
    logic             scl_nx, sda_nx;
    logic [DIV_W-1:0] clkdiv;
    logic             tick;

    logic wr, wr_cmd, wr_status, accept, cmd_err;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_cmd    = wr & (bus.address == ADDR_CMD);
    assign wr_status = wr & (bus.address == ADDR_STATUS);

    // A command landing on the edge where BUSY drops is taken, so back-to-back bytes need no gap
    assign done    = (state == S_HOLD) | ((state == S_STOP3) & tick);
    assign accept  = wr_cmd & lcd_i2c_en & (~busy | done);
    assign cmd_err = wr_cmd & ~accept;

    lcd_i2c_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state != S_IDLE),
        .clr     (accept),
        .div     (clkdiv),
        .tick    (tick)
    );

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        stop_f_nx  = stop_f;
        busy_nx    = busy;
        nack_set   = 1'b0;
        case (state)
            S_IDLE:   ;
            S_START1: if (tick) state_nx = S_START2;
            S_START2: if (tick) state_nx = S_BIT_LO;
            S_BIT_LO: if (tick) state_nx = S_BIT_HI;
            S_BIT_HI: if (tick) begin
                shift_nx   = {shift[6:0], 1'b0};
                bit_cnt_nx = bit_cnt - 3'd1;
                state_nx   = (bit_cnt != 3'd0) ? S_BIT_LO : S_ACK_LO;
            end
            S_ACK_LO: if (tick) state_nx = S_ACK_HI;
            S_ACK_HI: if (tick) begin
                nack_set = sda_in;
                state_nx = stop_f ? S_STOP1 : S_HOLD;
            end
            // HOLD only parks SCL low for the next byte; it does not wait for a tick
            S_HOLD: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
            S_STOP1:  if (tick) state_nx = S_STOP2;
            S_STOP2:  if (tick) state_nx = S_STOP3;
            S_STOP3:  if (tick) begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
            default:  state_nx = S_IDLE;
        endcase

        if (accept) begin
            state_nx   = bus.writedata[START_BIT] ? S_START1 : S_BIT_LO;
            shift_nx   = bus.writedata[7:0];
            bit_cnt_nx = 3'd7;
            stop_f_nx  = bus.writedata[STOP_BIT];
            busy_nx    = 1'b1;
        end

        if (state_nx == S_IDLE) begin
            {scl_nx, sda_nx} = {scl_oe, sda_oe};
        end else begin
            {scl_nx, sda_nx} = bus_drive(state_nx, shift_nx[7]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            stop_f  <= 1'b0;
            busy    <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            bit_cnt <= bit_cnt_nx;
            stop_f  <= stop_f_nx;
            busy    <= busy_nx;
            scl_oe  <= scl_nx;
            sda_oe  <= sda_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nack       <= 1'b0;
            err        <= 1'b0;
            clkdiv     <= DIV_RST;
            lcd_i2c_en <= 1'b0;
        end else begin
            nack <= (nack & ~(wr_status & bus.writedata[ST_NACK])) | nack_set;
            err  <= (err  & ~(wr_status & bus.writedata[ST_ERR]))  | cmd_err;
            if (wr & (bus.address == ADDR_CLKDIV) & ~busy)
                clkdiv <= bus.writedata[DIV_W-1:0];
            if (wr & (bus.address == ADDR_CONTROL))
                lcd_i2c_en <= bus.writedata[0];
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_STATUS:  bus.readdata = {29'd0, err, nack, busy};
            ADDR_CLKDIV:  bus.readdata = {{(32-DIV_W){1'b0}}, clkdiv};
            ADDR_CONTROL: bus.readdata = {31'd0, lcd_i2c_en};
            default:      bus.readdata = '0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:10];

endmodule
